comma_aligner: RTL

Parametrised serial comma aligner and deserialiser for the 8b10b receive path. Shifts in one encoded bit per enabled clock, detects the K28.5 comma in either running disparity, and runs a hunt/verify/lock state machine that fixes the symbol boundary. Once locked, it emits framed SYM_W-bit symbols with a one-cycle valid strobe. Sits between the serial line and the 8b10b decoder, replacing the single-pattern k28.5 detector.

---
 rtl/comma_aligner_pkg.sv | 11 +
 rtl/comma_aligner_if.sv | 23 ++
 rtl/comma_window.sv | 33 +++
 rtl/comma_aligner.sv | 138 +++++++++++++
 4 files changed

// File: rtl/comma_aligner_pkg.sv
// Shared definitions for the K28.5 comma aligner: FSM encodings and comma patterns.
package comma_aligner_pkg;
  typedef enum logic [1:0] {
    BUSCAR    = 2'd0,
    VERIFICAR = 2'd1,
    BLOQUEADO = 2'd2
  } estado_t;

  localparam logic [9:0] K28_5_NEG = 10'b001111_1010;
  localparam logic [9:0] K28_5_POS = 10'b110000_0101;
endpackage

// File: rtl/comma_aligner_if.sv
// Serial-in / framed-symbol-out bundle between the line side and the aligner.
interface comma_aligner_if #(
  parameter int SYM_W = 10
);
  logic             enb;
  logic             entrada;
  logic [SYM_W-1:0] simbolo;
  logic             simValid;
  logic             esComma;
  logic             rdPos;
  logic             bloqueado;
  logic [1:0]       estado;

  modport master (
    output enb, entrada,
    input  simbolo, simValid, esComma, rdPos, bloqueado, estado
  );

  modport slave (
    input  enb, entrada,
    output simbolo, simValid, esComma, rdPos, bloqueado, estado
  );
endinterface

// File: rtl/comma_window.sv
// Serial shift register presenting the SYM_W-bit window ending in the current bit,
// flagged valid only once the register has been completely filled since reset.
module comma_window
  import comma_aligner_pkg::*;
#(
  parameter int SYM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             entrada,
  output logic [SYM_W-1:0] window,
  output logic             window_valid
);
  localparam int FILL_W = $clog2(SYM_W-1) + 1;

  logic [SYM_W-2:0]  sr_reg;
  logic [FILL_W-1:0] fill_reg;

  assign window       = {sr_reg, entrada};
  assign window_valid = (fill_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg   <= '0;
      fill_reg <= FILL_W'(SYM_W-1);
    end else if (enb) begin
      sr_reg <= window[SYM_W-2:0];
      if (fill_reg != '0)
        fill_reg <= fill_reg - FILL_W'(1);
    end
  end
endmodule

// File: rtl/comma_aligner.sv
// K28.5 comma aligner: hunts for a comma in either disparity, verifies LOCK_N aligned
// commas, then emits one framed symbol per boundary until UNLOCK_N misaligned commas.
module comma_aligner
  import comma_aligner_pkg::*;
#(
  parameter int               SYM_W     = 10,
  parameter logic [SYM_W-1:0] COMMA_NEG = K28_5_NEG,
  parameter logic [SYM_W-1:0] COMMA_POS = K28_5_POS,
  parameter int               LOCK_N    = 3,
  parameter int               UNLOCK_N  = 2
) (
  input  logic           clk,
  input  logic           rst,
  comma_aligner_if.slave bus
);
  localparam int FASE_W = $clog2(SYM_W-1) + 1;
  localparam int OK_W   = $clog2(LOCK_N) + 1;
  localparam int ERR_W  = $clog2(UNLOCK_N) + 1;
  localparam logic [FASE_W-1:0] FASE_LAST = FASE_W'(SYM_W-1);

  logic [SYM_W-1:0]  window;
  logic              window_valid;
  estado_t           state_reg, state_next;
  logic [FASE_W-1:0] fase_reg, fase_next;
  logic [OK_W-1:0]   ok_reg, ok_next, ok_inc;
  logic [ERR_W-1:0]  err_reg, err_next, err_inc;
  logic [SYM_W-1:0]  simbolo_reg;
  logic              sim_valid_reg, es_comma_reg, rd_pos_reg;
  logic              match_neg, match_pos, match, boundary, emit;

  comma_window #(.SYM_W(SYM_W)) u_window (
    .clk          (clk),
    .rst          (rst),
    .enb          (bus.enb),
    .entrada      (bus.entrada),
    .window       (window),
    .window_valid (window_valid)
  );

  assign match_neg = window_valid && (window == COMMA_NEG);
  assign match_pos = window_valid && (window == COMMA_POS);
  assign match     = match_neg || match_pos;
  assign boundary  = (fase_reg == FASE_LAST);
  assign ok_inc    = ok_reg + OK_W'(1);
  assign err_inc   = err_reg + ERR_W'(1);
  assign emit      = (state_reg == BLOQUEADO) && boundary;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= BUSCAR;
      fase_reg  <= '0;
      ok_reg    <= '0;
      err_reg   <= '0;
    end else if (bus.enb) begin
      state_reg <= state_next;
      fase_reg  <= fase_next;
      ok_reg    <= ok_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fase_next  = boundary ? '0 : fase_reg + FASE_W'(1);
    ok_next    = ok_reg;
    err_next   = err_reg;
    unique case (state_reg)
      BUSCAR: begin
        if (match) begin
          fase_next = '0;
          ok_next   = OK_W'(1);
          if (LOCK_N == 1) begin
            state_next = BLOQUEADO;
            err_next   = '0;
          end else begin
            state_next = VERIFICAR;
          end
        end
      end
      VERIFICAR: begin
        // An off-boundary comma restarts verification from its own phase.
        if (match && boundary) begin
          ok_next = ok_inc;
          if (ok_inc == OK_W'(LOCK_N)) begin
            state_next = BLOQUEADO;
            err_next   = '0;
          end
        end else if (match) begin
          fase_next = '0;
          ok_next   = OK_W'(1);
        end
      end
      BLOQUEADO: begin
        // Misaligned commas never move the phase while locked; they only count.
        if (match && boundary) begin
          err_next = '0;
        end else if (match) begin
          if (err_inc == ERR_W'(UNLOCK_N)) begin
            state_next = BUSCAR;
            ok_next    = '0;
            err_next   = '0;
          end else begin
            err_next = err_inc;
          end
        end
      end
      default: state_next = BUSCAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      simbolo_reg   <= '0;
      sim_valid_reg <= 1'b0;
      es_comma_reg  <= 1'b0;
      rd_pos_reg    <= 1'b0;
    end else if (bus.enb) begin
      sim_valid_reg <= emit;
      es_comma_reg  <= match;
      if (emit)
        simbolo_reg <= window;
      if (match)
        rd_pos_reg <= match_pos;
    end else begin
      sim_valid_reg <= 1'b0;
    end
  end

  always_comb begin
    bus.estado    = state_reg;
    bus.bloqueado = (state_reg == BLOQUEADO);
  end

  assign bus.simbolo  = simbolo_reg;
  assign bus.simValid = sim_valid_reg;
  assign bus.esComma  = es_comma_reg;
  assign bus.rdPos    = rd_pos_reg;
endmodule
